// File: rtl/tnn_enc_pkg.sv
// Shared sizing, reset thresholds and FSM encoding for the TNN feature encoder.
// Q_W is fixed at 2 bits: a sample is placed in one of four threshold bands.
package tnn_enc_pkg;
  localparam int N_FEAT = 9;
  localparam int RAW_W  = 8;
  localparam int Q_W    = 2;

  localparam int DEF_THR [3] = '{64, 128, 192};

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;
endpackage

// File: rtl/tnn_feature_encoder_if.sv
// Encoder boundary bus: raw sample stream in, threshold config, packed vector out.
// The master side drives samples/config and m_ready; the slave side is the encoder.
interface tnn_feature_encoder_if #(
  parameter int N_FEAT = tnn_enc_pkg::N_FEAT,
  parameter int RAW_W  = tnn_enc_pkg::RAW_W,
  parameter int Q_W    = tnn_enc_pkg::Q_W
);
  logic                    s_valid;
  logic                    s_ready;
  logic [RAW_W-1:0]        s_data;
  logic                    s_last;
  logic                    cfg_we;
  logic [3:0]              cfg_feat;
  logic [1:0]              cfg_sel;
  logic [RAW_W-1:0]        cfg_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [N_FEAT*Q_W-1:0]   m_feat;

  modport master (
    output s_valid, s_data, s_last, cfg_we, cfg_feat, cfg_sel, cfg_data, m_ready,
    input  s_ready, m_valid, m_feat
  );

  modport slave (
    input  s_valid, s_data, s_last, cfg_we, cfg_feat, cfg_sel, cfg_data, m_ready,
    output s_ready, m_valid, m_feat
  );
endinterface

// File: rtl/tnn_quantizer.sv
// Combinational 2-bit quantizer: counts how many of three thresholds the sample meets.
// Threshold order is not assumed, so non-ascending thresholds still give a plain count.
module tnn_quantizer #(
  parameter int RAW_W = 8,
  parameter int Q_W   = 2
) (
  input  logic [RAW_W-1:0] sample,
  input  logic [RAW_W-1:0] t0,
  input  logic [RAW_W-1:0] t1,
  input  logic [RAW_W-1:0] t2,
  output logic [Q_W-1:0]   q
);
  logic ge0, ge1, ge2;

  assign ge0 = (sample >= t0);
  assign ge1 = (sample >= t1);
  assign ge2 = (sample >= t2);
  assign q   = Q_W'(ge0) + Q_W'(ge1) + Q_W'(ge2);
endmodule

// File: rtl/tnn_feature_encoder.sv
// Collects N_FEAT raw samples, quantizes each against per-feature thresholds and
// presents the packed vector one cycle after the last accept, held until m_ready.
module tnn_feature_encoder #(
  parameter int N_FEAT = tnn_enc_pkg::N_FEAT,
  parameter int RAW_W  = tnn_enc_pkg::RAW_W,
  parameter int Q_W    = tnn_enc_pkg::Q_W
) (
  input  logic                        clk,
  input  logic                        rst,
  tnn_feature_encoder_if.slave        bus,
  output logic                        err
);
  import tnn_enc_pkg::*;

  localparam int                IDX_W    = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FEAT - 1);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [RAW_W-1:0]       thr [N_FEAT][3];
  logic [Q_W-1:0]         slot [N_FEAT];
  logic [Q_W-1:0]         q;
  logic [N_FEAT*Q_W-1:0]  vec_nxt;
  logic [N_FEAT*Q_W-1:0]  feat_reg;
  logic                   accept;
  logic                   at_last;

  // One quantizer shared by all features; the threshold set follows the slot index.
  tnn_quantizer #(.RAW_W(RAW_W), .Q_W(Q_W)) u_quant (
    .sample (bus.s_data),
    .t0     (thr[idx][0]),
    .t1     (thr[idx][1]),
    .t2     (thr[idx][2]),
    .q      (q)
  );

  assign accept      = bus.s_valid && (state == COLLECT);
  assign at_last     = (idx == LAST_IDX);
  assign bus.m_feat  = feat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    case (state)
      COLLECT: begin
        bus.s_ready = 1'b1;
        if (accept && at_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // The final slot comes straight from the quantizer so the vector registers on the last accept.
  always_comb begin
    vec_nxt = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      vec_nxt[k*Q_W +: Q_W] = (k == N_FEAT - 1) ? q : slot[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      err      <= 1'b0;
      feat_reg <= '0;
      for (int k = 0; k < N_FEAT; k++) begin
        slot[k] <= '0;
      end
    end else if (accept) begin
      slot[idx] <= q;
      if (at_last) begin
        idx      <= '0;
        feat_reg <= vec_nxt;
        if (!bus.s_last) begin
          err <= 1'b1;
        end
      end else if (bus.s_last) begin
        // Early s_last: drop the partial vector and restart framing.
        idx <= '0;
        err <= 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Out-of-range feature or cfg_sel==3 simply matches no register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < N_FEAT; f++) begin
        for (int j = 0; j < 3; j++) begin
          thr[f][j] <= RAW_W'(DEF_THR[j]);
        end
      end
    end else begin
      for (int f = 0; f < N_FEAT; f++) begin
        for (int j = 0; j < 3; j++) begin
          if (bus.cfg_we && bus.cfg_feat == f[3:0] && bus.cfg_sel == j[1:0]) begin
            thr[f][j] <= bus.cfg_data;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tnn_feature_encoder.sv
// Scoreboard bench: a reference model predicts each packed vector as samples are
// accepted; every scenario task compares the DUT against the queued expectation.
module tb_tnn_feature_encoder;
  import tnn_enc_pkg::*;

  localparam int NF = N_FEAT;
  localparam int VW = N_FEAT * Q_W;

  logic clk = 1'b0;
  logic rst;
  logic err;

  tnn_feature_encoder_if #(.N_FEAT(NF), .RAW_W(RAW_W), .Q_W(Q_W)) bus ();

  tnn_feature_encoder #(.N_FEAT(NF), .RAW_W(RAW_W), .Q_W(Q_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0]    exp_q [$];
  logic [RAW_W-1:0] mthr  [NF][3];
  logic [Q_W-1:0]   mslot [NF];
  logic [RAW_W-1:0] vec   [NF];
  logic [VW-1:0]    exp_v;
  int               midx;
  logic             merr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int f = 0; f < NF; f++) begin
      mthr[f][0] = 8'd64;
      mthr[f][1] = 8'd128;
      mthr[f][2] = 8'd192;
    end
    midx = 0;
    merr = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic [Q_W-1:0] quant(input logic [RAW_W-1:0] d, input int f);
    int c = 0;
    for (int j = 0; j < 3; j++) if (d >= mthr[f][j]) c++;
    return Q_W'(c);
  endfunction

  function automatic void model_accept(input logic [RAW_W-1:0] d, input logic last);
    mslot[midx] = quant(d, midx);
    if (midx == NF - 1) begin
      logic [VW-1:0] v;
      for (int k = 0; k < NF; k++) v[k*Q_W +: Q_W] = mslot[k];
      exp_q.push_back(v);
      if (!last) merr = 1'b1;
      midx = 0;
    end else if (last) begin
      merr = 1'b1;
      midx = 0;
    end else begin
      midx++;
    end
  endfunction

  function automatic void model_cfg(input logic [3:0] f, input logic [1:0] s, input logic [RAW_W-1:0] d);
    if (int'(f) < NF && s != 2'd3) mthr[f][s] = d;
  endfunction

  task automatic send(input logic [RAW_W-1:0] d, input logic last, input logic cw,
                      input logic [3:0] cf, input logic [1:0] cs, input logic [RAW_W-1:0] cd);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    bus.cfg_we   = cw;
    bus.cfg_feat = cf;
    bus.cfg_sel  = cs;
    bus.cfg_data = cd;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait s_ready=%b required=1", bus.s_ready);
    end else begin
      model_accept(d, last);
    end
    if (cw) model_cfg(cf, cs, cd);
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.cfg_we  = 1'b0;
  endtask

  task automatic send_vec(input logic with_last, input int cfg_at, input logic [3:0] cf,
                          input logic [1:0] cs, input logic [RAW_W-1:0] cd);
    for (int i = 0; i < NF; i++) send(vec[i], with_last && (i == NF - 1), i == cfg_at, cf, cs, cd);
  endtask

  task automatic cfg_write(input logic [3:0] f, input logic [1:0] s, input logic [RAW_W-1:0] d);
    bus.cfg_we = 1'b1; bus.cfg_feat = f; bus.cfg_sel = s; bus.cfg_data = d;
    model_cfg(f, s, d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pop_and_compare(input string name);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_m_valid got=%b required=1", name, bus.m_valid);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard_empty got=%h required=<queued vector>", name, bus.m_feat);
    end else begin
      exp_v = exp_q.pop_front();
      if (bus.m_feat !== exp_v) begin
        failures++;
        $display("FAIL %s_m_feat got=%h required=%h", name, bus.m_feat, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_feat = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b required=1", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b required=0", bus.m_valid); end
    checks++; if (bus.m_feat !== '0) begin failures++; $display("FAIL reset_m_feat got=%h required=0", bus.m_feat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err); end
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    vec = '{8'd0, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255, 8'd63, 8'd200};
    send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
    checks++;
    if (bus.m_feat !== 18'h33E94) begin
      failures++;
      $display("FAIL basic_literal got=%h required=33e94", bus.m_feat);
    end
    pop_and_compare("basic");
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL basic_hold_s_ready got=%b required=0", bus.s_ready); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b required=0", err); end
    tick();
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL basic_release got=%b required=0", bus.m_valid); end
  endtask

  task automatic test_back_to_back();
    bus.m_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < NF; i++) vec[i] = RAW_W'($urandom_range(0, 255));
      send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
      pop_and_compare("b2b");
    end
    tick();
  endtask

  task automatic test_cfg();
    bus.m_ready = 1'b1;
    cfg_write(4'd2, 2'd0, 8'd10);
    cfg_write(4'd2, 2'd1, 8'd20);
    cfg_write(4'd2, 2'd2, 8'd30);
    vec = '{8'd70, 8'd130, 8'd25, 8'd200, 8'd0, 8'd64, 8'd5, 8'd255, 8'd128};
    send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
    pop_and_compare("cfg_new_thr");
    tick();
    // T1 of feature 2 rewritten in the same cycle as sample 25 at index 2.
    send_vec(1'b1, 2, 4'd2, 2'd1, 8'd26);
    pop_and_compare("cfg_same_cycle");
    tick();
    cfg_write(4'd9, 2'd0, 8'd0);
    cfg_write(4'd2, 2'd3, 8'd0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cfg_ignored_err got=%b required=0", err); end
    send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
    pop_and_compare("cfg_after_update");
    tick();
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    vec = '{8'd255, 8'd0, 8'd100, 8'd150, 8'd250, 8'd1, 8'd64, 8'd192, 8'd127};
    send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
    pop_and_compare("bp_first");
    bus.s_valid = 1'b1; bus.s_data = 8'd0; bus.s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        bus.cfg_we = 1'b1; bus.cfg_feat = 4'd0; bus.cfg_sel = 2'd0; bus.cfg_data = 8'd5;
        model_cfg(4'd0, 2'd0, 8'd5);
      end
      tick();
      bus.cfg_we = 1'b0;
      checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_m_valid got=%b required=1", bus.m_valid); end
      checks++; if (bus.m_feat !== exp_v) begin failures++; $display("FAIL bp_m_feat got=%h required=%h", bus.m_feat, exp_v); end
      checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready got=%b required=0", bus.s_ready); end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_resume_s_ready got=%b required=1", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL bp_resume_m_valid got=%b required=0", bus.m_valid); end
  endtask

  task automatic test_framing();
    bus.m_ready = 1'b1;
    send(8'd200, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0);
    send(8'd200, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0);
    send(8'd200, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0);
    send(8'd200, 1'b1, 1'b0, 4'd0, 2'd0, 8'd0);
    checks++; if (err !== merr) begin failures++; $display("FAIL early_last_err got=%b required=%b", err, merr); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL early_last_m_valid got=%b required=0", bus.m_valid); end
    vec = '{8'd5, 8'd4, 8'd66, 8'd129, 8'd193, 8'd0, 8'd255, 8'd127, 8'd191};
    send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
    pop_and_compare("after_framing");
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b required=1", err); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(8'd250, 1'b0, 1'b0, 4'd0, 2'd0, 8'd0);
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b required=0", err); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid got=%b required=0", bus.m_valid); end
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL midrst_s_ready got=%b required=1", bus.s_ready); end
    vec = '{8'd5, 8'd64, 8'd25, 8'd0, 8'd128, 8'd191, 8'd192, 8'd63, 8'd255};
    send_vec(1'b1, -1, 4'd0, 2'd0, 8'd0);
    pop_and_compare("midrst_vec");
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_vec_err got=%b required=0", err); end
    tick();
  endtask

  task automatic test_no_last();
    bus.m_ready = 1'b1;
    vec = '{8'd1, 8'd65, 8'd129, 8'd193, 8'd0, 8'd0, 8'd255, 8'd255, 8'd100};
    send_vec(1'b0, -1, 4'd0, 2'd0, 8'd0);
    pop_and_compare("no_last");
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL no_last_err got=%b required=1", err); end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cfg();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_no_last();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
